// File: rtl/hamm_pkg.sv
// hamm_pkg: shared types and helpers for the 11/16 SECDED decoder.
// Word bit i is Hamming position i; p0 is overall even parity.
package hamm_pkg;

  typedef enum logic [2:0] {
    GET_LSW = 3'd0,
    GET_MSW = 3'd1,
    CHECK   = 3'd2,
    FIX     = 3'd3,
    OUT     = 3'd4
  } state_t;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_DBL   = 2'b10;

  localparam int unsigned DATA_POS [11] = '{
    3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15
  };

  function automatic logic [10:0] extract_data(
    input logic [15:0] w
  );
    logic [10:0] d;
    d = '0;
    for (int i = 0; i < 11; i++) begin
      d[i] = w[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// hamm_syndrome: combinational syndrome and overall parity.
// Shared with the encoder self-check path.
module hamm_syndrome (
  input  logic [15:0] word,
  output logic [3:0]  s,
  output logic        ovr
);

  // XOR of the indices of every set bit at positions 1..15
  always_comb begin
    s = '0;
    for (int i = 1; i < 16; i++) begin
      if (word[i]) begin
        s = s ^ i[3:0];
      end
    end
    ovr = ^word;
  end

endmodule

// File: rtl/hamm_decoder.sv
// hamm_decoder: two-beat receive, syndrome check, SECDED fix.
// One word in flight; saturating corrected/double counters.
module hamm_decoder
  import hamm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic [1:0]       out_status,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  lsw;
  logic [7:0]  msw;
  logic [15:0] word;
  logic [3:0]  syn_c;
  logic        ovr_c;
  logic [3:0]  syn_q;
  logic        ovr_q;
  logic [15:0] fixed_word;
  logic [1:0]  fix_status;
  logic        do_fix;

  assign word      = {msw, lsw};
  assign in_ready  = (state == GET_LSW) ||
                     (state == GET_MSW);
  assign out_valid = (state == OUT);
  assign do_fix    = (state == FIX);

  hamm_syndrome u_syn (
    .word (word),
    .s    (syn_c),
    .ovr  (ovr_c)
  );

  // next-state selection for the word sequencer
  always_comb begin
    state_nxt = state;
    unique case (state)
      GET_LSW: if (in_valid) state_nxt = GET_MSW;
      GET_MSW: if (in_valid) state_nxt = CHECK;
      CHECK:   state_nxt = FIX;
      FIX:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = GET_LSW;
      default: state_nxt = GET_LSW;
    endcase
  end

  // sequencer state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= GET_LSW;
    end else begin
      state <= state_nxt;
    end
  end

  // beat capture; a reset drops any half-received word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lsw <= '0;
      msw <= '0;
    end else begin
      if (state == GET_LSW && in_valid) lsw <= in_byte;
      if (state == GET_MSW && in_valid) msw <= in_byte;
    end
  end

  // syndrome is registered so FIX sees a stable value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      syn_q <= '0;
      ovr_q <= 1'b0;
    end else if (state == CHECK) begin
      syn_q <= syn_c;
      ovr_q <= ovr_c;
    end
  end

  // classify the word and repair a single flipped bit
  always_comb begin
    fixed_word = word;
    fix_status = ST_CLEAN;
    unique case (1'b1)
      (ovr_q && syn_q != 4'd0): begin
        fixed_word = word ^ (16'd1 << syn_q);
        fix_status = ST_CORR;
      end
      (ovr_q && syn_q == 4'd0): begin
        fix_status = ST_CORR;
      end
      (!ovr_q && syn_q != 4'd0): begin
        fix_status = ST_DBL;
      end
      default: begin
        fix_status = ST_CLEAN;
      end
    endcase
  end

  // result registers hold through backpressure and after handoff
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_status <= ST_CLEAN;
    end else if (do_fix) begin
      out_data   <= extract_data(fixed_word);
      out_status <= fix_status;
    end
  end

  // saturating counters; a clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (!reset_n || clr_cnt) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (do_fix) begin
      if (fix_status == ST_CORR && corr_cnt != '1) begin
        corr_cnt <= corr_cnt + 1'b1;
      end
      if (fix_status == ST_DBL && dbl_cnt != '1) begin
        dbl_cnt <= dbl_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamm_decoder.sv
// tb_hamm_decoder: random and directed checks of hamm_decoder
// against an encode-and-inject reference model.
module tb_hamm_decoder;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic             out_valid;
  logic             out_ready;
  logic [10:0]      out_data;
  logic [1:0]       out_status;
  logic             clr_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] dbl_cnt;

  int errors;
  int checks;
  int corr_m;
  int dbl_m;

  hamm_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .dbl_cnt    (dbl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Hamming(15,11) plus overall parity, built from first principles
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int k;
    logic par;
    w = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if (!is_pow2(p)) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if (((p >> b) & 1) == 1 && p != (1 << b)) par ^= w[p];
      end
      w[1 << b] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] raw_data(input logic [15:0] w);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if (!is_pow2(p)) begin
        d[k] = w[p];
        k++;
      end
    end
    return d;
  endfunction

  task automatic model_cnt(input logic [1:0] st, input bit clr);
    if (clr) begin
      corr_m = 0;
      dbl_m  = 0;
    end else if (st == 2'b01) begin
      if (corr_m < CMAX) corr_m++;
    end else if (st == 2'b10) begin
      if (dbl_m < CMAX) dbl_m++;
    end
  endtask

  // drive one codeword; verifies handshake timing along the way
  task automatic xfer(
    input  logic [15:0] w,
    input  bit          clr_fix,
    input  int          bp,
    output logic [10:0] d,
    output logic [1:0]  st
  );
    in_valid = 1'b1;
    in_byte  = w[7:0];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rdy_lsw: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_byte = w[15:8];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rdy_msw: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat0: out_valid=%b in_ready=%b want 0 0",
               out_valid, in_ready);
    end
    @(posedge clk); #1;
    if (clr_fix) clr_cnt = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1: out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    clr_cnt   = 1'b0;
    out_ready = (bp == 0);
    if (bp > 0) begin
      in_valid = 1'b1;
      in_byte  = 8'hA5;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat2: out_valid=%b want 1", out_valid);
    end
    d  = out_data;
    st = out_status;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_data !== d || out_status !== st) begin
        errors++;
        $display("FAIL bp_hold: v=%b rdy=%b d=%h st=%b want 1 0 %h %b",
                 out_valid, in_ready, out_data, out_status, d, st);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== d) begin
      errors++;
      $display("FAIL post_hs: out_valid=%b d=%h want 0 %h",
               out_valid, out_data, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_word(
    input string       name,
    input logic [10:0] d,
    input logic [1:0]  st,
    input logic [10:0] d_exp,
    input logic [1:0]  st_exp
  );
    checks++;
    if (d !== d_exp || st !== st_exp) begin
      errors++;
      $display("FAIL %s: data=%h st=%b want %h %b",
               name, d, st, d_exp, st_exp);
    end
    checks++;
    if (corr_cnt !== corr_m[CNT_W-1:0] ||
        dbl_cnt !== dbl_m[CNT_W-1:0]) begin
      errors++;
      $display("FAIL %s_cnt: corr=%0d dbl=%0d want %0d %0d",
               name, corr_cnt, dbl_cnt, corr_m, dbl_m);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    corr_m = 0;
    dbl_m  = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== 11'h000 || out_status !== 2'b00 ||
        corr_cnt !== '0 || dbl_cnt !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b v=%b d=%h st=%b c=%0d b=%0d",
               in_ready, out_valid, out_data, out_status,
               corr_cnt, dbl_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [10:0] d;
    logic [1:0]  st;
    xfer(16'h000F, 1'b0, 0, d, st);
    model_cnt(2'b00, 1'b0);
    check_word("clean", d, st, 11'h001, 2'b00);
    xfer(16'h020F, 1'b0, 0, d, st);
    model_cnt(2'b01, 1'b0);
    check_word("pos9", d, st, 11'h001, 2'b01);
    xfer(16'h000E, 1'b0, 0, d, st);
    model_cnt(2'b01, 1'b0);
    check_word("p0err", d, st, 11'h001, 2'b01);
    xfer(16'h006F, 1'b0, 0, d, st);
    model_cnt(2'b10, 1'b0);
    check_word("dbl56", d, st, 11'h007, 2'b10);
  endtask

  task automatic test_backpressure();
    logic [10:0] d;
    logic [1:0]  st;
    logic [10:0] dr;
    xfer(16'h020F, 1'b0, 5, d, st);
    model_cnt(2'b01, 1'b0);
    check_word("bp_word", d, st, 11'h001, 2'b01);
    dr = 11'($urandom);
    xfer(encode(dr), 1'b0, 0, d, st);
    model_cnt(2'b00, 1'b0);
    check_word("bp_next", d, st, dr, 2'b00);
  endtask

  task automatic test_saturation();
    logic [10:0] d;
    logic [1:0]  st;
    logic [10:0] dr;
    logic [15:0] w;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    model_cnt(2'b00, 1'b1);
    @(negedge clk);
    checks++;
    if (corr_cnt !== '0 || dbl_cnt !== '0) begin
      errors++;
      $display("FAIL clr_idle: corr=%0d dbl=%0d want 0 0",
               corr_cnt, dbl_cnt);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      dr = 11'($urandom);
      w  = encode(dr);
      w[$urandom_range(0, 15)] ^= 1'b1;
      xfer(w, (i == 5), 0, d, st);
      model_cnt(2'b01, (i == 5));
      check_word("sat", d, st, dr, 2'b01);
    end
  endtask

  task automatic test_reset_midword();
    logic [10:0] d;
    logic [1:0]  st;
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    corr_m = 0;
    dbl_m  = 0;
    xfer(16'h000F, 1'b0, 0, d, st);
    model_cnt(2'b00, 1'b0);
    check_word("rst_mid", d, st, 11'h001, 2'b00);
  endtask

  task automatic test_random();
    logic [10:0] d;
    logic [1:0]  st;
    logic [10:0] dr;
    logic [10:0] de;
    logic [1:0]  se;
    logic [15:0] w;
    int nerr;
    int pa;
    int pb;
    for (int n = 0; n < 40; n++) begin
      dr   = 11'($urandom);
      w    = encode(dr);
      nerr = $urandom_range(0, 2);
      pa   = $urandom_range(0, 15);
      pb   = (pa + $urandom_range(1, 15)) % 16;
      if (nerr >= 1) w[pa] ^= 1'b1;
      if (nerr == 2) w[pb] ^= 1'b1;
      case (nerr)
        0: begin de = dr; se = 2'b00; end
        1: begin de = dr; se = 2'b01; end
        default: begin de = raw_data(w); se = 2'b10; end
      endcase
      xfer(w, 1'b0, $urandom_range(0, 2), d, st);
      model_cnt(se, 1'b0);
      check_word("rand", d, st, de, se);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    corr_m    = 0;
    dbl_m     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_saturation();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
